// File: rtl/ysyx_23060184_ifu_axi_fetch_pkg.sv
// rtl/ysyx_23060184_ifu_axi_fetch_pkg.sv - shared widths, AXI encodings and IFU state type
package ysyx_23060184_ifu_axi_fetch_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ID_WIDTH    = 4;
    localparam int ALEN        = 8;
    localparam int ASIZE       = 3;
    localparam int ABURST      = 2;
    localparam int ACERR_WIDTH = 2;

    localparam logic [DATA_WIDTH-1:0]  INST_NOP       = 32'h0000_0013;
    localparam logic [ABURST-1:0]      AXI_BURST_INCR = 2'b01;
    localparam logic [ASIZE-1:0]       AXI_SIZE_4B    = 3'b010;
    localparam logic [ACERR_WIDTH-1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_REQ,
        IFU_AR,
        IFU_RD,
        IFU_DRAIN
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060184_sync_fifo.sv
// rtl/ysyx_23060184_sync_fifo.sv - synchronous FIFO with clear and occupancy count
module ysyx_23060184_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ysyx_23060184_ifu_axi_fetch.sv
// rtl/ysyx_23060184_ifu_axi_fetch.sv - AXI4 burst instruction fetcher; IFU_RRESP_CHECK_EN enables rresp fault tagging
module ysyx_23060184_ifu_axi_fetch
    import ysyx_23060184_ifu_axi_fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ID_W      = ID_WIDTH,
    parameter int FETCH_ID  = 0,
    parameter int BURST_LEN = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              flush,
    input  logic              stall,
    input  logic              grant,
    output logic              busreq,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic              idle
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

    ifu_state_e        state_q, state_d;
    logic              busreq_q, busreq_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] beat_pc_q, beat_pc_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;
    logic              beat;
    logic              fifo_push;
    logic [DATA_W-1:0] beat_data;
    logic              beat_err;
    logic [ENT_W-1:0]  head;

    // Credits are checked only when a request is taken; the buffer can only drain until its beats land.
    assign free      = DEPTH_C - count;
    assign req_ready = (state_q == IFU_IDLE) & ~flush & (free >= BURST_C);
    assign rready    = rready_q & grant;
    assign beat      = rvalid & rready;
    assign fifo_push = beat & (state_q == IFU_RD) & ~flush;

`ifdef IFU_RRESP_CHECK_EN
    assign beat_err  = (rresp != AXI_RESP_OKAY);
    assign beat_data = beat_err ? INST_NOP : rdata;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign beat_err     = 1'b0;
    assign beat_data    = rdata;
`endif

    always_comb begin
        state_d    = state_q;
        busreq_d   = busreq_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        araddr_d   = araddr_q;
        beat_pc_d  = beat_pc_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IFU_IDLE: begin
                if (req_valid && req_ready) begin
                    araddr_d = req_pc;
                    busreq_d = 1'b1;
                    state_d  = IFU_REQ;
                end
            end
            IFU_REQ: begin
                if (flush) begin
                    busreq_d = 1'b0;
                    state_d  = IFU_IDLE;
                end else if (grant && !stall) begin
                    arvalid_d = 1'b1;
                    state_d   = IFU_AR;
                end
            end
            IFU_AR: begin
                if (arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    beat_pc_d  = araddr_q;
                    beat_cnt_d = '0;
                    state_d    = flush ? IFU_DRAIN : IFU_RD;
                end else if (flush) begin
                    state_d = IFU_DRAIN;
                end
            end
            IFU_RD: begin
                if (beat) begin
                    beat_pc_d  = beat_pc_q + ADDR_W'(4);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (rlast || (beat_cnt_d == BURST_C)) begin
                        rready_d = 1'b0;
                        busreq_d = 1'b0;
                        state_d  = IFU_IDLE;
                    end else if (flush) begin
                        state_d = IFU_DRAIN;
                    end
                end else if (flush) begin
                    state_d = IFU_DRAIN;
                end
            end
            IFU_DRAIN: begin
                // A flush taken in AR still owes the address handshake before beats can be discarded.
                if (arvalid_q) begin
                    if (arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                    end
                end else if (beat && rlast) begin
                    rready_d = 1'b0;
                    busreq_d = 1'b0;
                    state_d  = IFU_IDLE;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IFU_IDLE;
            busreq_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
            beat_pc_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busreq_q   <= busreq_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            araddr_q   <= araddr_d;
            beat_pc_q  <= beat_pc_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    ysyx_23060184_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (flush),
        .push      (fifo_push),
        .push_data ({beat_pc_q, beat_data, beat_err}),
        .pop       (inst_valid & inst_ready),
        .pop_data  (head),
        .count     (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head[DATA_W:1] : INST_NOP;
    assign inst_pc    = inst_valid ? head[ENT_W-1 -: ADDR_W] : '0;
    assign inst_err   = inst_valid & head[0];

    assign busreq  = busreq_q;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign arid    = ID_W'(FETCH_ID);
    assign arlen   = ALEN'(BURST_LEN - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign idle    = (state_q == IFU_IDLE) & ~busreq_q;

endmodule

// File: tb/tb_ysyx_23060184_ifu_axi_fetch.sv
// tb/tb_ysyx_23060184_ifu_axi_fetch.sv - randomized bench with AXI slave and queue reference model
module tb_ysyx_23060184_ifu_axi_fetch;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int FETCH_ID  = 0;
    localparam int BURST_LEN = 2;
    localparam int BUF_DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              flush;
    logic              stall;
    logic              grant;
    logic              busreq;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_err;
    logic              idle;

    always #5 clk = ~clk;

    ysyx_23060184_ifu_axi_fetch #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .FETCH_ID  (FETCH_ID),
        .BURST_LEN (BURST_LEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .flush      (flush),
        .stall      (stall),
        .grant      (grant),
        .busreq     (busreq),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rready     (rready),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_err   (inst_err),
        .idle       (idle)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } ent_t;

    ent_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          busy, ar_started, ar_done, killed, exp_arvalid, rv_hold, dir_mode;
    logic [31:0] txn_pc;
    logic [31:0] beat_addr;
    int          beats_left;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return (w[4:2] == 3'b000) ? 2'b10 : 2'b00;
    endfunction

    function automatic ent_t make_ent(input logic [31:0] a);
        ent_t e;
        e.pc = a;
`ifdef IFU_RRESP_CHECK_EN
        e.err  = (mem_resp(a) != 2'b00);
        e.data = e.err ? NOP : mem_word(a);
`else
        e.err  = 1'b0;
        e.data = mem_word(a);
`endif
        return e;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy = 0; ar_started = 0; ar_done = 0; killed = 0;
        exp_arvalid = 0; rv_hold = 0; beats_left = 0; txn_pc = '0; beat_addr = '0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_busreq", busreq, 1'b0);
        check_eq("rst_inst_valid", inst_valid, 1'b0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_inst_err", inst_err, 1'b0);
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_araddr", araddr, 32'h0);
        check_eq("rst_arid", arid, FETCH_ID);
        check_eq("rst_arlen", arlen, BURST_LEN - 1);
        check_eq("rst_arsize", arsize, 3'b010);
        check_eq("rst_arburst", arburst, 2'b01);
    endtask

    // One clock: drive at negedge, check combinational outputs, advance the model at posedge,
    // then check registered outputs at the following negedge.
    task automatic run_cycle();
        bit req_hs, ar_hs, r_hs, pop, fl, last, next_arv;
        if (dir_mode) begin
            grant = 1; stall = 0; flush = 0; inst_ready = 1; arready = 1;
            req_valid = 1; req_pc = 32'h8000_0000;
        end else begin
            grant      = ($urandom_range(0, 9) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 29) == 0);
            inst_ready = ($urandom_range(0, 9) < 6);
            arready    = $urandom_range(0, 1);
            req_valid  = $urandom_range(0, 1);
            req_pc     = $urandom & 32'hFFFF_FFFC;
        end
        if (beats_left > 0 && (rv_hold || dir_mode || $urandom_range(0, 9) < 7)) begin
            rvalid = 1;
            rdata  = mem_word(beat_addr);
            rresp  = mem_resp(beat_addr);
            rlast  = (beats_left == 1);
        end else begin
            rvalid = 0;
            rdata  = $urandom;
            rresp  = 2'($urandom_range(0, 3));
            rlast  = $urandom_range(0, 1);
        end
        #1;
        check_eq("req_ready", req_ready,
                 !busy && !flush && (BUF_DEPTH - exp_q.size() >= BURST_LEN));
        check_eq("rready", rready, grant && ar_done);
        req_hs = req_valid & req_ready;
        ar_hs  = arvalid & arready;
        r_hs   = rvalid & rready;
        pop    = inst_valid & inst_ready;
        fl     = flush;
        last   = rlast;
        if (ar_hs) begin
            check_eq("araddr", araddr, txn_pc);
            check_eq("arlen", arlen, BURST_LEN - 1);
            check_eq("arid", arid, FETCH_ID);
            check_eq("arsize", arsize, 3'b010);
            check_eq("arburst", arburst, 2'b01);
        end
        @(posedge clk);
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        next_arv = ar_hs ? 1'b0 :
                   (exp_arvalid ? 1'b1 : (busy && !ar_started && grant && !stall && !fl));
        if (next_arv) ar_started = 1;
        if (fl) begin
            exp_q.delete();
            if (busy && ar_started) killed = 1;
            else if (busy) begin busy = 0; ar_started = 0; end
        end
        if (ar_hs) begin
            ar_done    = 1;
            beats_left = BURST_LEN;
            beat_addr  = txn_pc;
        end
        if (r_hs) begin
            if (!killed && !fl) exp_q.push_back(make_ent(beat_addr));
            beats_left--;
            beat_addr += 4;
            if (last) begin busy = 0; ar_done = 0; killed = 0; ar_started = 0; end
        end
        rv_hold = rvalid && !r_hs;
        if (req_hs) begin busy = 1; ar_started = 0; killed = 0; txn_pc = req_pc; end
        exp_arvalid = next_arv;
        @(negedge clk);
        check_eq("arvalid", arvalid, exp_arvalid);
        check_eq("busreq", busreq, busy);
        check_eq("idle", idle, !busy);
        check_eq("inst_valid", inst_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("inst", inst, exp_q[0].data);
            check_eq("inst_pc", inst_pc, exp_q[0].pc);
            check_eq("inst_err", inst_err, exp_q[0].err);
        end
    endtask

    initial begin
        bit reached;
        resetn = 0; req_valid = 0; req_pc = '0; flush = 0; stall = 0; grant = 1;
        arready = 0; rdata = '0; rresp = '0; rvalid = 0; rlast = 0; inst_ready = 0;
        dir_mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        resetn = 1;

        dir_mode = 1;
        repeat (12) run_cycle();
        dir_mode = 0;
        repeat (3000) run_cycle();

        dir_mode = 1;
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            run_cycle();
            if (ar_done && beats_left == BURST_LEN) reached = 1;
        end
        check_eq("reach_rd", reached, 1'b1);
        resetn = 0; rvalid = 1; rlast = 0; grant = 1; req_valid = 0; inst_ready = 0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        resetn = 1; rvalid = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_empty", inst_valid, 1'b0);
        check_eq("post_rst_idle", idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
